fetch_aligner: RTL
==================

Name: fetch_aligner

Overview:
- Instruction-fetch stage of the RV32IMC core; requests 32-bit aligned words from instruction memory.
- Realigns the returned halfwords into whole instructions: 16-bit compressed, or 32-bit that may straddle a word boundary.
- Presents the instructions with their PC to decode over a valid/ready handshake.
- A redirect/flush input restarts fetching at any halfword-aligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- arstn  input  1  asynchronous active-low reset.
- flush  input  1  redirect request; highest priority.
- flushPc  input  32  redirect target; bit 0 treated as 0.
- memReq  output  1  fetch request to instruction memory.
- memAddr  output  32  word address of the request; bits [1:0] always 0.
- memGnt  input  1  request accepted this cycle.
- memRvalid  input  1  read data valid; at least 1 cycle after the grant.
- memRdata  input  32  read data; halfword 0 = bits [15:0].
- instrValid  output  1  instr/instrPc/instrCompressed are valid.
- instrReady  input  1  decode accepts the instruction.
- instr  output  32  instruction; upper 16 bits zero when compressed.
- instrPc  output  32  PC of instr.
- instrCompressed  output  1  instr is a 16-bit encoding.

Behaviour:
- Reset (async on arstn low):
  - Halfword buffer empty (count=0, contents 0).
  - instrPc = RESET_PC with bit 0 cleared; fetchAddr = RESET_PC & ~3; dropLow = RESET_PC[1].
  - outstanding = 0, discard = 0.
  - Outputs: memReq=0, instrValid=0, instr=0, instrCompressed=0.
- Buffer:
  - 4-entry halfword FIFO; count 0..4; hw0 is the oldest entry.
- Output decode (combinational from buffer):
  - compressed = (hw0[1:0] != 2'b11) and count >= 1.
  - need = 1 if compressed, else 2.
  - instrValid = (count >= need) and !flush.
  - instr = compressed ? {16'h0, hw0} : {hw1, hw0}.
  - Outputs are don't-care-free: zeros when the buffer is empty.
- Pop:
  - On instrValid & instrReady, remove `need` halfwords; instrPc += 2 or 4, mod 2^32.
  - Outputs must stay stable while instrValid & !instrReady.
- Fetch:
  - memReq = !outstanding & !flush & (count <= 2).
  - memAddr = fetchAddr.
  - Once memReq is asserted, memAddr is held until memGnt or flush.
  - On memReq & memGnt: outstanding = 1; fetchAddr += 4, mod 2^32.
- Response:
  - On memRvalid: outstanding = 0.
  - If discard is set: drop the data and clear discard.
  - Else if dropLow is set: push only memRdata[31:16] and clear dropLow.
  - Else push [15:0] then [31:16].
- Pop and push in the same cycle are both applied. count_next = count - popped + pushed, never exceeding 4, guaranteed by the count <= 2 issue rule.
- Flush (any cycle, overrides pop and push):
  - Buffer emptied; instrPc = flushPc & ~1; fetchAddr = flushPc & ~3; dropLow = flushPc[1].
  - discard = 1 if outstanding is set and no memRvalid arrives this cycle.
  - Data on a memRvalid in the same cycle is dropped and outstanding clears.
  - memReq is forced low this cycle; fetching restarts the next cycle.
- A grant in the flush cycle cannot occur, because memReq=0.
- At most one outstanding request at any time.
- A 32-bit instruction with only hw0 buffered keeps instrValid=0 until the next word arrives.
- Reset mid-transaction: all state cleared asynchronously; any late memRvalid after reset release with outstanding=0 is ignored.
- Addresses wrap: fetchAddr 32'hFFFF_FFFC + 4 = 0.

Test Plan:
- Reset, RESET_PC=0; memory words 0x00A00093, 0x00100113; grant and rvalid after 1 cycle -> memAddr 0x0, then 0x4; two instrs, instrPc 0x0 then 0x4, instrCompressed=0.
- Word 0x4505_0505 (two compressed instructions) with instrReady=1 -> instr 0x0505 at PC 0x0, then 0x4505 at PC 0x2; each instrCompressed=1; fetch proceeds to 0x4.
- Word 0 = {0x0093, 0x4505}, word 1 = {0x1234, 0x00A0} -> compressed 0x4505 @0x0, then 32-bit 0x00A00093 @0x2 straddling the words.
- Flush with flushPc=0x102 while a request is outstanding -> stale rvalid data discarded; next memAddr 0x100; only the upper halfword is used; first instrPc 0x102.
- instrReady=0 for 10 cycles -> buffer fills to 4; memReq stays 0 once count > 2; instr/instrPc stable; no overflow; stream resumes in order when ready rises.
- Flush at fetchAddr 0xFFFF_FFFC -> request at 0xFFFF_FFFC, then memAddr wraps to 0x0000_0000; pulsing arstn low mid-request -> memReq=0, instrValid=0 immediately.

Source files
------------

// File: rtl/fetch_aligner.sv
// Fetch stage: requests aligned words, realigns halfwords into
// 16/32-bit instructions and hands them to decode with their PC.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        flush,
  input  logic [31:0] flushPc,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        instrCompressed
);

  logic [15:0] buf_q [4];
  logic [15:0] buf_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] faddr_q, faddr_d;
  logic        drop_q, drop_d;
  logic        outst_q, outst_d;
  logic        disc_q, disc_d;
  logic        run_q;
  logic        is_c, pop, grant, accept;
  logic [2:0]  need;
  logic        unused_pc0;

  assign unused_pc0 = flushPc[0];

  always_comb begin
    is_c = (cnt_q != 3'd0) && (buf_q[0][1:0] != 2'b11);
    need = is_c ? 3'd1 : 3'd2;
    instrValid = (cnt_q >= need) && !flush;
    instrCompressed = is_c;
    if (cnt_q == 3'd0) instr = '0;
    else if (is_c)     instr = {16'h0, buf_q[0]};
    else               instr = {buf_q[1], buf_q[0]};
    instrPc = pc_q;
    // run_q keeps the request low while in reset and one cycle after
    memReq = run_q && !outst_q && !flush && (cnt_q <= 3'd2);
    memAddr = faddr_q;
    pop = instrValid && instrReady;
    grant = memReq && memGnt;
    accept = memRvalid && outst_q && !disc_q;
  end

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (pop) begin
      if (is_c) begin
        buf_d[0] = buf_q[1];
        buf_d[1] = buf_q[2];
        buf_d[2] = buf_q[3];
        buf_d[3] = '0;
      end else begin
        buf_d[0] = buf_q[2];
        buf_d[1] = buf_q[3];
        buf_d[2] = '0;
        buf_d[3] = '0;
      end
      cnt_d = cnt_q - need;
    end
    if (accept) begin
      if (drop_q) begin
        buf_d[cnt_d[1:0]] = memRdata[31:16];
        cnt_d = cnt_d + 3'd1;
      end else begin
        buf_d[cnt_d[1:0]] = memRdata[15:0];
        buf_d[cnt_d[1:0] + 2'd1] = memRdata[31:16];
        cnt_d = cnt_d + 3'd2;
      end
    end
    if (flush) begin
      for (int i = 0; i < 4; i++) buf_d[i] = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    pc_d = pc_q;
    faddr_d = faddr_q;
    drop_d = drop_q;
    outst_d = outst_q;
    disc_d = disc_q;
    if (memRvalid) outst_d = 1'b0;
    if (grant) outst_d = 1'b1;
    if (flush) begin
      pc_d = {flushPc[31:1], 1'b0};
      faddr_d = {flushPc[31:2], 2'b00};
      drop_d = flushPc[1];
      // an in-flight word belongs to the old stream
      disc_d = outst_q && !memRvalid;
    end else begin
      if (pop) pc_d = pc_q + (is_c ? 32'd2 : 32'd4);
      if (grant) faddr_d = faddr_q + 32'd4;
      if (accept) drop_d = 1'b0;
      if (memRvalid && outst_q) disc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      cnt_q <= '0;
      pc_q <= {RESET_PC[31:1], 1'b0};
      faddr_q <= {RESET_PC[31:2], 2'b00};
      drop_q <= RESET_PC[1];
      outst_q <= 1'b0;
      disc_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      faddr_q <= faddr_d;
      drop_q <= drop_d;
      outst_q <= outst_d;
      disc_q <= disc_d;
      run_q <= 1'b1;
    end
  end

endmodule
